spi_cmd_controller: RTL and testbench

Byte-level command sequencer between the SPI slave front end and the design's register file. It consumes the received byte stream and frame-boundary pulses and decodes a one-byte command header. It then issues register writes, or register reads with prefetch, and supplies the next transmit byte plus a load strobe. The SPI slave shifts that byte out during the following byte slot.

---
 rtl/spi_cmd_controller.sv | 176 +++++++++++++++++
 tb/tb_spi_cmd_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_controller.sv
// spi_cmd_controller: byte-level command sequencer between an SPI slave
// front end and a register file. Decodes a one-byte header (RD, AINC, addr),
// then issues register writes or prefetched register reads and hands the
// SPI slave the next transmit byte together with a load strobe.
// Optional feature macro: SPI_CMD_RANGE_CHECK_EN (flags and blocks accesses
// at addresses >= NUM_REGS; reads of such addresses return 8'hFF).
module spi_cmd_controller #(
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

`ifdef SPI_CMD_RANGE_CHECK_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif
  localparam logic [ADDR_W:0] NumRegsW = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_REQ,
    RD_CAP,
    RD
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] regAddr_q;
  logic [7:0]        regWdata_q;
  logic [7:0]        txData_q;
  logic [6:0]        frameCnt_q;
  logic              ainc_q;
  logic              err_q;
  logic              busy_q;
  logic              txLoad_q;
  logic              regWe_q;
  logic              regRe_q;
  logic              rdOor_q;

  logic [ADDR_W-1:0] hdrAddr;
  logic [ADDR_W-1:0] nextAddr;
  logic [ADDR_W-1:0] reqAddr;
  logic              wrCommit;
  logic              rdIssue;
  logic              wrOor;
  logic              rdOor;
  logic              protoErr;
  logic              errSet;
  logic [7:0]        capData;

  // Decode this cycle's byte/frame events into write, read and error intents.
  always_comb begin
    hdrAddr  = rx_data[ADDR_W-1:0];
    nextAddr = ainc_q ? addr_q + ADDR_W'(1) : addr_q;
    reqAddr  = (state_q == CMD) ? hdrAddr : nextAddr;
    wrCommit = rx_valid && (state_q == WR);
    rdIssue  = rx_valid && !frame_start && !frame_end &&
               (((state_q == CMD) && rx_data[7]) || (state_q == RD));
    wrOor    = RangeEn && ({1'b0, addr_q} >= NumRegsW);
    rdOor    = RangeEn && ({1'b0, reqAddr} >= NumRegsW);
    protoErr = rx_valid && ((state_q == IDLE) || (state_q == RD_REQ) ||
                            (state_q == RD_CAP));
    errSet   = protoErr || (wrCommit && wrOor) || (rdIssue && rdOor);
    capData  = rdOor_q ? 8'hFF : reg_rdata;
  end

  // Sequencer FSM with all strobes and data outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      regAddr_q  <= '0;
      regWdata_q <= 8'h00;
      txData_q   <= 8'h00;
      frameCnt_q <= 7'd0;
      ainc_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      txLoad_q   <= 1'b0;
      regWe_q    <= 1'b0;
      regRe_q    <= 1'b0;
      rdOor_q    <= 1'b0;
    end else begin
      txLoad_q <= 1'b0;
      regWe_q  <= 1'b0;
      regRe_q  <= 1'b0;

      if (errSet) begin
        err_q <= 1'b1;
      end

      if (wrCommit) begin
        regAddr_q  <= addr_q;
        regWdata_q <= rx_data;
        regWe_q    <= !wrOor;
        txData_q   <= rx_data;
        txLoad_q   <= 1'b1;
        addr_q     <= nextAddr;
      end

      if (rdIssue) begin
        regAddr_q <= reqAddr;
        regRe_q   <= !rdOor;
        rdOor_q   <= rdOor;
        addr_q    <= reqAddr;
      end

      if (frame_start) begin
        state_q    <= CMD;
        busy_q     <= 1'b1;
        txData_q   <= {err_q, frameCnt_q};
        txLoad_q   <= 1'b1;
        frameCnt_q <= frameCnt_q + 7'd1;
        err_q      <= errSet;
      end else if (frame_end) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          CMD: begin
            if (rx_valid) begin
              ainc_q <= rx_data[6];
              if (rx_data[7]) begin
                state_q <= RD_REQ;
              end else begin
                addr_q  <= hdrAddr;
                state_q <= WR;
              end
            end
          end
          RD_REQ: begin
            txLoad_q <= 1'b1;
            state_q  <= RD_CAP;
          end
          RD_CAP: begin
            txData_q <= capData;
            state_q  <= RD;
          end
          RD: begin
            if (rx_valid) begin
              state_q <= RD_REQ;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign tx_data   = (state_q == RD_CAP) ? capData : txData_q;
  assign tx_load   = txLoad_q;
  assign reg_addr  = regAddr_q;
  assign reg_wdata = regWdata_q;
  assign reg_we    = regWe_q;
  assign reg_re    = regRe_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// tb_spi_cmd_controller: directed-vector bench for spi_cmd_controller.
// Honours SPI_CMD_RANGE_CHECK_EN for the out-of-range read vector.
module tb_spi_cmd_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       frame_end;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  int checkCount = 0;
  int errCount   = 0;
  int reCount    = 0;
  int weCount    = 0;
  int reBefore;
  int weBefore;

  logic [7:0] regMem [64];
  logic [7:0] wrData [3];

  spi_cmd_controller #(.ADDR_W(6), .NUM_REGS(48)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .busy        (busy)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Register-file model: read data appears the cycle after reg_re; strobes are tallied.
  always @(posedge clk) begin
    if (reg_re) begin
      reg_rdata <= regMem[reg_addr];
      reCount   <= reCount + 1;
    end
    if (reg_we) begin
      weCount <= weCount + 1;
    end
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then leave the bench looking at the following cycle.
  task automatic applyStimulus(input logic fs, input logic fe, input logic rv,
                               input logic [7:0] data);
    frame_start = fs;
    frame_end   = fe;
    rx_valid    = rv;
    rx_data     = data;
    tick();
    frame_start = 1'b0;
    frame_end   = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
  endtask

  // Directed scenario sequence.
  initial begin
    for (int i = 0; i < 64; i++) regMem[i] = 8'h00;
    regMem[0]  = 8'h11;
    regMem[1]  = 8'h22;
    regMem[50] = 8'h77;
    wrData[0]  = 8'hA1;
    wrData[1]  = 8'hB2;
    wrData[2]  = 8'hC3;
    reg_rdata   = 8'h00;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;

    #3;
    checkOutput("rst tx_data", tx_data, 8'h00);
    checkOutput("rst tx_load", tx_load, 1'b0);
    checkOutput("rst reg_we", reg_we, 1'b0);
    checkOutput("rst reg_re", reg_re, 1'b0);
    checkOutput("rst busy", busy, 1'b0);
    checkOutput("rst reg_addr", reg_addr, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Write burst with auto-increment from address 5.
    reBefore = reCount;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("wr status load", tx_load, 1'b1);
    checkOutput("wr status byte", tx_data, 8'h00);
    checkOutput("wr busy", busy, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h45);
    checkOutput("wr hdr no we", reg_we, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, wrData[i]);
      checkOutput("wr we", reg_we, 1'b1);
      checkOutput("wr addr", reg_addr, 6'd5 + 6'(i));
      checkOutput("wr wdata", reg_wdata, wrData[i]);
      checkOutput("wr echo load", tx_load, 1'b1);
      checkOutput("wr echo data", tx_data, wrData[i]);
      tick();
      checkOutput("wr we single", reg_we, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("wr busy drop", busy, 1'b0);
    checkOutput("wr no reads", reCount - reBefore, 0);

    // Read burst with auto-increment from address 0.
    weBefore = weCount;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("rd status byte", tx_data, 8'h01);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hC0);
    checkOutput("rd re0", reg_re, 1'b1);
    checkOutput("rd addr0", reg_addr, 6'd0);
    checkOutput("rd early load", tx_load, 1'b0);
    tick();
    checkOutput("rd load0", tx_load, 1'b1);
    checkOutput("rd data0", tx_data, 8'h11);
    tick();
    checkOutput("rd load0 single", tx_load, 1'b0);
    checkOutput("rd data0 held", tx_data, 8'h11);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("rd re1", reg_re, 1'b1);
    checkOutput("rd addr1", reg_addr, 6'd1);
    tick();
    checkOutput("rd load1", tx_load, 1'b1);
    checkOutput("rd data1", tx_data, 8'h22);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("rd no writes", weCount - weBefore, 0);

    // Address wrap 63 -> 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("wrap status", tx_data, 8'h02);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h7F);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A);
    checkOutput("wrap addr63", reg_addr, 6'd63);
    checkOutput("wrap data63", reg_wdata, 8'h5A);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h6B);
    checkOutput("wrap we0", reg_we, 1'b1);
    checkOutput("wrap addr0", reg_addr, 6'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    // Byte while idle sets err; status read clears it.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h99);
    checkOutput("idle byte no load", tx_load, 1'b0);
    checkOutput("idle byte no we", reg_we, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("err status", tx_data, 8'h83);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("err cleared", tx_data, 8'h04);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    // Overrun: byte arrives during RD_REQ, read still completes.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("ovr status", tx_data, 8'h05);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h80);
    checkOutput("ovr re", reg_re, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h55);
    checkOutput("ovr load", tx_load, 1'b1);
    checkOutput("ovr data", tx_data, 8'h11);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("ovr err status", tx_data, 8'h86);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    // frame_end together with a write byte still commits the write.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("fe status", tx_data, 8'h07);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h02);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C);
    checkOutput("fe we", reg_we, 1'b1);
    checkOutput("fe addr", reg_addr, 6'd2);
    checkOutput("fe wdata", reg_wdata, 8'h3C);
    checkOutput("fe busy", busy, 1'b0);

    // frame_start inside an open frame restarts it.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("rs status a", tx_data, 8'h08);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h41);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("rs load", tx_load, 1'b1);
    checkOutput("rs status b", tx_data, 8'h09);
    checkOutput("rs busy", busy, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    // Read at address 50 (beyond NUM_REGS).
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("rng status", tx_data, 8'h0A);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hB2);
`ifdef SPI_CMD_RANGE_CHECK_EN
    checkOutput("rng no re", reg_re, 1'b0);
    tick();
    checkOutput("rng load", tx_load, 1'b1);
    checkOutput("rng data", tx_data, 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("rng err status", tx_data, 8'h8B);
`else
    checkOutput("rng re", reg_re, 1'b1);
    checkOutput("rng addr", reg_addr, 6'd50);
    tick();
    checkOutput("rng load", tx_load, 1'b1);
    checkOutput("rng data", tx_data, 8'h77);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("rng status after", tx_data, 8'h0B);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset in the middle of a write.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("mid status", tx_data, 8'h0C);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h45);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h9D);
    checkOutput("mid we before rst", reg_we, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid rst we", reg_we, 1'b0);
    checkOutput("mid rst load", tx_load, 1'b0);
    checkOutput("mid rst tx_data", tx_data, 8'h00);
    checkOutput("mid rst addr", reg_addr, 6'd0);
    checkOutput("mid rst wdata", reg_wdata, 8'h00);
    checkOutput("mid rst busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("post rst load", tx_load, 1'b1);
    checkOutput("post rst status", tx_data, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
